// File: rtl/baudgen_pkg.sv
// rtl/baudgen_pkg.sv - shared defaults and increment calculator for the fractional baud generator
package baudgen_pkg;

  // Reset defaults for a 50 MHz system clock
  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD      = 115_200;
  localparam int DEF_OVERSAMPLE = 4;
  localparam int DEF_ACC_WIDTH = 16;

  // Rounded increment so that f_clk * inc / 2^w approximates tick_hz.
  // Both operands are pre-scaled by 16 to keep the 64-bit product in range.
  function automatic longint unsigned calc_inc(input longint unsigned clk_hz,
                                               input longint unsigned tick_hz,
                                               input int unsigned     w);
    return ((tick_hz << (w - 4)) + (clk_hz >> 5)) / (clk_hz >> 4);
  endfunction

endpackage

// File: rtl/baudgen_frac_if.sv
// rtl/baudgen_frac_if.sv - control and tick bundle of the fractional baud generator
interface baudgen_frac_if
  import baudgen_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
);
  localparam int PHASE_W = $clog2(OVERSAMPLE);

  logic                 en;
  logic                 resync;
  logic                 inc_wr;
  logic [ACC_WIDTH-1:0] inc_din;
  logic [ACC_WIDTH-1:0] inc_q;
  logic                 upd_pend;
  logic                 os_tick;
  logic                 bit_tick;
  logic [PHASE_W-1:0]   os_phase;

  modport master (
    output en, resync, inc_wr, inc_din,
    input  inc_q, upd_pend, os_tick, bit_tick, os_phase
  );

  modport slave (
    input  en, resync, inc_wr, inc_din,
    output inc_q, upd_pend, os_tick, bit_tick, os_phase
  );

endinterface

// File: rtl/baudgen_phase.sv
// rtl/baudgen_phase.sv - oversample phase counter producing the bit-centre tick
module baudgen_phase #(
  parameter int OVERSAMPLE = 4,
  parameter int PHASE_W    = $clog2(OVERSAMPLE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               os_tick,
  input  logic               resync,
  input  logic [PHASE_W-1:0] load,
  output logic [PHASE_W-1:0] phase,
  output logic               bit_tick
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(OVERSAMPLE - 1);

  assign bit_tick = os_tick & (phase == LAST);

  // Count oversample ticks within a bit; resync re-centres ahead of any pending tick
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (resync) begin
      phase <= load;
    end else if (os_tick) begin
      phase <= (phase == LAST) ? '0 : phase + PHASE_W'(1);
    end
  end

endmodule

// File: rtl/baudgen_frac.sv
// rtl/baudgen_frac.sv - fractional-N baud generator with runtime increment, enable and resync
module baudgen_frac
  import baudgen_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int RESYNC_PHASE = OVERSAMPLE / 2,
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT =
    ACC_WIDTH'(calc_inc(64'(CLK_FREQ), 64'(BAUD * OVERSAMPLE), ACC_WIDTH))
) (
  input logic           clk,
  input logic           rst,
  baudgen_frac_if.slave bus
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);

  // MSB holds the carry of the last add and is the registered os_tick
  logic [ACC_WIDTH:0]   acc;
  logic [ACC_WIDTH-1:0] inc_active;
  logic [ACC_WIDTH-1:0] inc_pend;
  logic                 upd_pend;
  logic [PHASE_W-1:0]   phase;
  logic                 bit_tick;
  logic                 apply;

  // A new increment is only swapped in at a bit boundary or while stopped
  assign apply = bit_tick | ~bus.en;

  assign bus.os_tick  = acc[ACC_WIDTH];
  assign bus.bit_tick = bit_tick;
  assign bus.os_phase = phase;
  assign bus.inc_q    = inc_active;
  assign bus.upd_pend = upd_pend;

  // Phase accumulator: fraction wraps freely, carry becomes the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.resync) begin
      acc <= '0;
    end else if (bus.en) begin
      acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, inc_active};
    end else begin
      acc <= {1'b0, acc[ACC_WIDTH-1:0]};
    end
  end

  // Increment shadow register: writes park in inc_pend until the next apply point
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_active <= INC_DEFAULT;
      inc_pend   <= '0;
      upd_pend   <= 1'b0;
    end else if (apply) begin
      if (bus.inc_wr) begin
        inc_active <= bus.inc_din;
      end else if (upd_pend) begin
        inc_active <= inc_pend;
      end
      upd_pend <= 1'b0;
    end else if (bus.inc_wr) begin
      inc_pend <= bus.inc_din;
      upd_pend <= 1'b1;
    end
  end

  baudgen_phase #(
    .OVERSAMPLE (OVERSAMPLE),
    .PHASE_W    (PHASE_W)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .os_tick  (acc[ACC_WIDTH]),
    .resync   (bus.resync),
    .load     (PHASE_W'(RESYNC_PHASE)),
    .phase    (phase),
    .bit_tick (bit_tick)
  );

endmodule
